// File: rtl/fpu_decode_queue.sv
// fpu_decode_queue
// FP instruction decode stage for the FPU front end. Raw 32-bit F/D-extension
// instructions arrive over a valid/ready handshake, are decoded into a
// micro-op record (operation, format, register fields, resolved rounding mode,
// load/store offset, class, illegal flag) and buffered in a QDEPTH-entry FIFO
// that the FPU issue logic drains.
//
// Parameters:
//   FLEN    32 = F only, 64 = F+D (double format, FLD/FSD, FCVT.S.D/FCVT.D.S)
//   QDEPTH  FIFO entries, power of two, at least 2
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all queued entries, blocks a same-cycle push
//   in_valid/in_ready   instruction handshake (instr, frm sampled on push)
//   out_valid/out_ready head-entry handshake
//   op, fmt, rd, rs1, rs2, rs3, rm, imm, cls, illegal   head record
//   illegal_cnt         saturating count of illegal pushes
module fpu_decode_queue #(
  parameter int FLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [2:0]  frm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  op,
  output logic        fmt,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  output logic [2:0]  rm,
  output logic [11:0] imm,
  output logic [1:0]  cls,
  output logic        illegal,
  output logic [15:0] illegal_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [4:0] {
    OP_NONE    = 5'd0,  OP_LOAD    = 5'd1,  OP_STORE   = 5'd2,
    OP_MADD    = 5'd3,  OP_MSUB    = 5'd4,  OP_NMSUB   = 5'd5,
    OP_NMADD   = 5'd6,  OP_ADD     = 5'd7,  OP_SUB     = 5'd8,
    OP_MUL     = 5'd9,  OP_DIV     = 5'd10, OP_SQRT    = 5'd11,
    OP_SGNJ    = 5'd12, OP_SGNJN   = 5'd13, OP_SGNJX   = 5'd14,
    OP_MIN     = 5'd15, OP_MAX     = 5'd16, OP_CVT_W   = 5'd17,
    OP_CVT_WU  = 5'd18, OP_CVT_F_W = 5'd19, OP_CVT_F_WU = 5'd20,
    OP_MV_X_F  = 5'd21, OP_CLASS   = 5'd22, OP_MV_F_X  = 5'd23,
    OP_EQ      = 5'd24, OP_LT      = 5'd25, OP_LE      = 5'd26,
    OP_CVT_S_D = 5'd27, OP_CVT_D_S = 5'd28
  } op_e;

  typedef struct packed {
    op_e         op;
    logic        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  rm;
    logic [11:0] imm;
    logic [1:0]  cls;
    logic        illegal;
  } rec_t;

  logic [6:0] f_opc;
  logic [4:0] f_rd, f_rs1, f_rs2, f_funct5;
  logic [2:0] f_funct3, rm_res;
  logic [1:0] f_fmt;
  logic       fmt_ok, use_rm, bad;
  rec_t       dec;

  assign f_opc    = instr[6:0];
  assign f_rd     = instr[11:7];
  assign f_funct3 = instr[14:12];
  assign f_rs1    = instr[19:15];
  assign f_rs2    = instr[24:20];
  assign f_fmt    = instr[26:25];
  assign f_funct5 = instr[31:27];
  assign rm_res   = (f_funct3 == 3'b111) ? frm : f_funct3;
  assign fmt_ok   = (f_fmt == 2'b00) || ((f_fmt == 2'b01) && (FLEN == 64));

  // Decode: pick the op and the operand fields it actually uses, then collapse
  // the whole record to the canonical illegal form if any rule was broken.
  always_comb begin
    dec    = '0;
    use_rm = 1'b0;
    bad    = 1'b0;
    case (f_opc)
      7'b0000111, 7'b0100111: begin
        if (f_opc[5]) begin
          dec.op  = OP_STORE;
          dec.cls = 2'b10;
          dec.rs2 = f_rs2;
          dec.imm = {instr[31:25], instr[11:7]};
        end else begin
          dec.op  = OP_LOAD;
          dec.cls = 2'b01;
          dec.rd  = f_rd;
          dec.imm = instr[31:20];
        end
        dec.rs1 = f_rs1;
        if (f_funct3 == 3'b010)                       dec.fmt = 1'b0;
        else if (f_funct3 == 3'b011 && FLEN == 64)    dec.fmt = 1'b1;
        else                                          bad = 1'b1;
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        case (f_opc[3:2])
          2'b00:   dec.op = OP_MADD;
          2'b01:   dec.op = OP_MSUB;
          2'b10:   dec.op = OP_NMSUB;
          default: dec.op = OP_NMADD;
        endcase
        dec.cls = 2'b11;
        dec.fmt = f_fmt[0];
        dec.rd  = f_rd;
        dec.rs1 = f_rs1;
        dec.rs2 = f_rs2;
        dec.rs3 = f_funct5;
        use_rm  = 1'b1;
        bad     = !fmt_ok;
      end
      7'b1010011: begin
        dec.cls = 2'b11;
        dec.fmt = f_fmt[0];
        dec.rd  = f_rd;
        dec.rs1 = f_rs1;
        bad     = !fmt_ok;
        case (f_funct5)
          5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
            case (f_funct5[1:0])
              2'b00:   dec.op = OP_ADD;
              2'b01:   dec.op = OP_SUB;
              2'b10:   dec.op = OP_MUL;
              default: dec.op = OP_DIV;
            endcase
            dec.rs2 = f_rs2;
            use_rm  = 1'b1;
          end
          5'b01011: begin
            dec.op = OP_SQRT;
            use_rm = 1'b1;
            if (f_rs2 != 5'd0) bad = 1'b1;
          end
          5'b00100: begin
            dec.rs2 = f_rs2;
            case (f_funct3)
              3'b000:  dec.op = OP_SGNJ;
              3'b001:  dec.op = OP_SGNJN;
              3'b010:  dec.op = OP_SGNJX;
              default: bad = 1'b1;
            endcase
          end
          5'b00101: begin
            dec.rs2 = f_rs2;
            case (f_funct3)
              3'b000:  dec.op = OP_MIN;
              3'b001:  dec.op = OP_MAX;
              default: bad = 1'b1;
            endcase
          end
          5'b11000, 5'b11010: begin
            use_rm = 1'b1;
            if (f_rs2 == 5'd0)      dec.op = f_funct5[1] ? OP_CVT_F_W  : OP_CVT_W;
            else if (f_rs2 == 5'd1) dec.op = f_funct5[1] ? OP_CVT_F_WU : OP_CVT_WU;
            else                    bad = 1'b1;
          end
          5'b11100: begin
            if (f_rs2 != 5'd0)                              bad = 1'b1;
            else if (f_funct3 == 3'b000 && f_fmt == 2'b00)  dec.op = OP_MV_X_F;
            else if (f_funct3 == 3'b001)                    dec.op = OP_CLASS;
            else                                            bad = 1'b1;
          end
          5'b11110: begin
            dec.op = OP_MV_F_X;
            if (f_funct3 != 3'b000 || f_rs2 != 5'd0 || f_fmt != 2'b00) bad = 1'b1;
          end
          5'b10100: begin
            dec.rs2 = f_rs2;
            case (f_funct3)
              3'b010:  dec.op = OP_EQ;
              3'b001:  dec.op = OP_LT;
              3'b000:  dec.op = OP_LE;
              default: bad = 1'b1;
            endcase
          end
          5'b01000: begin
            // Cross-format conversions exist only when the D extension does.
            use_rm = 1'b1;
            if (f_fmt == 2'b00 && f_rs2 == 5'd1)      dec.op = OP_CVT_S_D;
            else if (f_fmt == 2'b01 && f_rs2 == 5'd0) dec.op = OP_CVT_D_S;
            else                                      bad = 1'b1;
            if (FLEN != 64) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (use_rm) begin
      dec.rm = rm_res;
      if (rm_res == 3'b101 || rm_res == 3'b110) bad = 1'b1;
    end
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  rec_t          mem [QDEPTH];
  rec_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign in_ready  = (count != CW'(QDEPTH)) && !rst;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Storage carries no reset; empty-queue outputs are forced to zero below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push && dec.illegal && illegal_cnt != 16'hFFFF)
        illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign op      = head.op;
  assign fmt     = head.fmt;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign rs3     = head.rs3;
  assign rm      = head.rm;
  assign imm     = head.imm;
  assign cls     = head.cls;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_fpu_decode_queue.sv
// tb_fpu_decode_queue
// Self-checking bench for fpu_decode_queue (FLEN=32, QDEPTH=2). A reference
// model decodes each offered instruction from the instruction-set rules and
// keeps the expected FIFO contents in a queue; directed scenarios are followed
// by a randomized burst driven with $urandom.
module tb_fpu_decode_queue;

  localparam int TB_FLEN = 32;
  localparam int QD      = 2;

  localparam int OP_NONE = 0, OP_LOAD = 1, OP_STORE = 2, OP_MADD = 3, OP_NMADD = 6;
  localparam int OP_DIV = 10, OP_SQRT = 11, OP_SGNJ = 12, OP_MIN = 15, OP_MAX = 16;
  localparam int OP_CVT_W = 17, OP_CVT_F_W = 19, OP_CVT_F_WU = 20, OP_MV_X_F = 21;
  localparam int OP_CLASS = 22, OP_MV_F_X = 23, OP_EQ = 24, OP_LT = 25, OP_LE = 26;
  localparam int OP_CVT_S_D = 27, OP_CVT_D_S = 28;

  typedef struct packed {
    logic [4:0]  op;
    logic        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  rm;
    logic [11:0] imm;
    logic [1:0]  cls;
    logic        ill;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  frm = '0;
  logic        in_ready, out_valid, fmt, illegal;
  logic [4:0]  op, rd, rs1, rs2, rs3;
  logic [2:0]  rm;
  logic [11:0] imm;
  logic [1:0]  cls;
  logic [15:0] illegal_cnt;
  rec_t        dut_rec;

  int   checks = 0;
  int   failures = 0;
  rec_t model_q[$];
  logic [15:0] model_ill = '0;

  fpu_decode_queue #(.FLEN(TB_FLEN), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .frm(frm), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rm(rm),
    .imm(imm), .cls(cls), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  assign dut_rec = {op, fmt, rd, rs1, rs2, rs3, rm, imm, cls, illegal};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: choose the op from the encoding rules, then derive the
  // fields from what that op reads.
  function automatic rec_t ref_decode(input logic [31:0] i, input logic [2:0] dyn);
    rec_t r;
    int o;
    logic [6:0] opc;
    logic [4:0] f5, s2;
    logic [2:0] f3, rmv;
    logic [1:0] fm;
    logic fmt_legal, uses_rm;
    opc = i[6:0]; f3 = i[14:12]; s2 = i[24:20]; fm = i[26:25]; f5 = i[31:27];
    r = '0;
    o = OP_NONE;
    fmt_legal = (fm == 2'd0) || (fm == 2'd1 && TB_FLEN == 64);
    if (opc == 7'b0000111 || opc == 7'b0100111) begin
      if (f3 == 3'd2 || (f3 == 3'd3 && TB_FLEN == 64)) o = opc[5] ? OP_STORE : OP_LOAD;
      r.fmt = f3[0];
    end else if (opc[6:4] == 3'b100 && opc[1:0] == 2'b11) begin
      if (fmt_legal) o = OP_MADD + int'(opc[3:2]);
      r.fmt = fm[0];
    end else if (opc == 7'b1010011) begin
      r.fmt = fm[0];
      case (f5)
        5'd0, 5'd1, 5'd2, 5'd3: o = 7 + int'(f5);
        5'd11: o = (s2 == 0) ? OP_SQRT : OP_NONE;
        5'd4:  o = (f3 <= 2) ? OP_SGNJ + int'(f3) : OP_NONE;
        5'd5:  o = (f3 <= 1) ? OP_MIN + int'(f3) : OP_NONE;
        5'd24: o = (s2 <= 1) ? OP_CVT_W + int'(s2) : OP_NONE;
        5'd26: o = (s2 <= 1) ? OP_CVT_F_W + int'(s2) : OP_NONE;
        5'd28: o = (s2 != 0) ? OP_NONE : (f3 == 0 && fm == 0) ? OP_MV_X_F :
                   (f3 == 1) ? OP_CLASS : OP_NONE;
        5'd30: o = (f3 == 0 && s2 == 0 && fm == 0) ? OP_MV_F_X : OP_NONE;
        5'd20: o = (f3 == 2) ? OP_EQ : (f3 == 1) ? OP_LT : (f3 == 0) ? OP_LE : OP_NONE;
        5'd8:  o = (TB_FLEN != 64) ? OP_NONE : (fm == 0 && s2 == 1) ? OP_CVT_S_D :
                   (fm == 1 && s2 == 0) ? OP_CVT_D_S : OP_NONE;
        default: o = OP_NONE;
      endcase
      if (!fmt_legal) o = OP_NONE;
    end
    uses_rm = (o >= OP_MADD && o <= OP_SQRT) || (o >= OP_CVT_W && o <= OP_CVT_F_WU) ||
              o >= OP_CVT_S_D;
    rmv = (f3 == 3'b111) ? dyn : f3;
    if (uses_rm && (rmv == 3'd5 || rmv == 3'd6)) o = OP_NONE;
    if (o == OP_NONE) begin
      r = '0;
      r.ill = 1'b1;
      return r;
    end
    r.op  = 5'(o);
    r.rs1 = i[19:15];
    if (o == OP_LOAD) begin
      r.rd = i[11:7]; r.imm = i[31:20]; r.cls = 2'd1;
      return r;
    end
    if (o == OP_STORE) begin
      r.rs2 = s2; r.imm = {i[31:25], i[11:7]}; r.cls = 2'd2;
      return r;
    end
    r.cls = 2'd3;
    r.rd  = i[11:7];
    if (uses_rm) r.rm = rmv;
    if (o <= OP_NMADD) r.rs3 = f5;
    if (o <= OP_DIV || (o >= OP_SGNJ && o <= OP_MAX) || (o >= OP_EQ && o <= OP_LE))
      r.rs2 = s2;
    return r;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fm,
                                      input logic [4:0] s2, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d,
                                      input logic [6:0] opc);
    return {f5, fm, s2, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 11))
      0: x[6:0] = 7'b0000111;
      1: x[6:0] = 7'b0100111;
      2, 3: x[6:0] = {3'b100, 2'($urandom_range(0, 3)), 2'b11};
      11: ;
      default: begin
        x[6:0] = 7'b1010011;
        case ($urandom_range(0, 12))
          0: x[31:27] = 5'd0;   1: x[31:27] = 5'd1;   2: x[31:27] = 5'd2;
          3: x[31:27] = 5'd3;   4: x[31:27] = 5'd11;  5: x[31:27] = 5'd4;
          6: x[31:27] = 5'd5;   7: x[31:27] = 5'd24;  8: x[31:27] = 5'd26;
          9: x[31:27] = 5'd28;  10: x[31:27] = 5'd30; 11: x[31:27] = 5'd20;
          default: x[31:27] = 5'd8;
        endcase
      end
    endcase
    if ($urandom_range(0, 3) != 0) x[26:25] = 2'($urandom_range(0, 1));
    if ($urandom_range(0, 1) != 0) x[24:20] = 5'($urandom_range(0, 2));
    if ($urandom_range(0, 1) != 0) x[14:12] = 3'($urandom_range(0, 3));
    return x;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, then
  // compare the DUT against it at the next falling edge.
  task automatic applyStimulus(input logic r, input logic fl, input logic iv,
                               input logic [31:0] ins, input logic [2:0] f,
                               input logic ordy, output logic acc);
    rec_t d;
    logic do_pop;
    rst = r; flush = fl; in_valid = iv; instr = ins; frm = f; out_ready = ordy;
    #1;
    checkOutput("in_ready", 64'(in_ready), 64'(!r && model_q.size() < QD));
    acc = 1'b0;
    if (r) begin
      model_q.delete();
      model_ill = '0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      acc    = iv && (model_q.size() < QD);
      do_pop = ordy && (model_q.size() > 0);
      d      = ref_decode(ins, f);
      if (do_pop) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(d);
        if (d.ill && model_ill != 16'hFFFF) model_ill = model_ill + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    checkOutput("illegal_cnt", 64'(illegal_cnt), 64'(model_ill));
    if (model_q.size() > 0) checkOutput("head_record", 64'(dut_rec), 64'(model_q[0]));
  endtask

  logic        acc;
  logic [31:0] fadd_s = 32'h003100D3;

  initial begin
    // Reset and idle state.
    applyStimulus(1, 0, 1, fadd_s, 3'd0, 0, acc);
    applyStimulus(1, 0, 0, 32'd0, 3'd0, 0, acc);
    checkOutput("reset_record", 64'(dut_rec), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);

    // FADD.S, fields checked against hand-decoded constants.
    applyStimulus(0, 0, 1, fadd_s, 3'd0, 0, acc);
    checkOutput("fadd_op", 64'(op), 64'd7);
    checkOutput("fadd_rd", 64'(rd), 64'd1);
    checkOutput("fadd_rs1", 64'(rs1), 64'd2);
    checkOutput("fadd_rs2", 64'(rs2), 64'd3);
    checkOutput("fadd_rm", 64'(rm), 64'd0);
    checkOutput("fadd_cls", 64'(cls), 64'd3);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);

    // FMADD.D is illegal with FLEN=32.
    applyStimulus(0, 0, 1, enc(5'd4, 2'b01, 5'd3, 5'd2, 3'b000, 5'd1, 7'b1000011), 3'd0, 0, acc);
    checkOutput("fmaddd_illegal", 64'(illegal), 64'd1);
    checkOutput("fmaddd_op", 64'(op), 64'd0);
    checkOutput("fmaddd_cnt", 64'(illegal_cnt), 64'd1);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);

    // Dynamic rounding mode resolving to a reserved value.
    applyStimulus(0, 0, 1, 32'h003170D3, 3'b101, 0, acc);
    checkOutput("dynrm_illegal", 64'(illegal), 64'd1);
    checkOutput("dynrm_cnt", 64'(illegal_cnt), 64'd2);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);

    // FNMADD.S with dynamic rounding.
    applyStimulus(0, 0, 1, enc(5'd5, 2'b00, 5'd3, 5'd2, 3'b111, 5'd1, 7'b1001111), 3'b010, 0, acc);
    checkOutput("fnmadd_op", 64'(op), 64'd6);
    checkOutput("fnmadd_rs3", 64'(rs3), 64'd5);
    checkOutput("fnmadd_rm", 64'(rm), 64'd2);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);

    // FSW with the largest positive offset.
    applyStimulus(0, 0, 1, {7'h3F, 5'd4, 5'd6, 3'b010, 5'h1F, 7'b0100111}, 3'd0, 0, acc);
    checkOutput("fsw_op", 64'(op), 64'd2);
    checkOutput("fsw_cls", 64'(cls), 64'd2);
    checkOutput("fsw_imm", 64'(imm), 64'h7FF);
    checkOutput("fsw_rd", 64'(rd), 64'd0);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);

    // Fill with out_ready low, hold a third offer, then drain in order.
    applyStimulus(0, 0, 1, enc(5'd0, 2'b00, 5'd1, 5'd1, 3'b000, 5'd1, 7'b1010011), 3'd0, 0, acc);
    applyStimulus(0, 0, 1, enc(5'd1, 2'b00, 5'd2, 5'd2, 3'b001, 5'd2, 7'b1010011), 3'd0, 0, acc);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 0, 1, enc(5'd2, 2'b00, 5'd3, 5'd3, 3'b010, 5'd3, 7'b1010011), 3'd0, 0, acc);
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 1, enc(5'd2, 2'b00, 5'd3, 5'd3, 3'b010, 5'd3, 7'b1010011), 3'd0, 1, acc);
    applyStimulus(0, 0, 1, enc(5'd3, 2'b00, 5'd4, 5'd4, 3'b000, 5'd4, 7'b1010011), 3'd0, 0, acc);
    applyStimulus(0, 0, 1, enc(5'd3, 2'b00, 5'd5, 5'd5, 3'b000, 5'd5, 7'b1010011), 3'd0, 0, acc);

    // Full queue with both sides active: the head must never drop out.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, enc(5'd4, 2'b00, 5'(k), 5'(k + 1), 3'b000, 5'(k + 2), 7'b1010011),
                    3'd0, 1, acc);
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
    end

    // Flush while two entries are queued and an illegal instruction is offered.
    applyStimulus(0, 0, 1, fadd_s, 3'd0, 0, acc);
    applyStimulus(0, 1, 1, 32'd0, 3'd0, 0, acc);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_cnt", 64'(illegal_cnt), 64'd2);
    applyStimulus(0, 0, 0, 32'd0, 3'd0, 1, acc);
    checkOutput("flush_after_valid", 64'(out_valid), 64'd0);

    // Reset mid-burst.
    applyStimulus(0, 0, 1, fadd_s, 3'd0, 0, acc);
    applyStimulus(1, 0, 1, fadd_s, 3'd0, 0, acc);
    applyStimulus(1, 0, 1, fadd_s, 3'd0, 1, acc);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_record", 64'(dut_rec), 64'd0);
    checkOutput("rst_cnt", 64'(illegal_cnt), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0), rand_instr(), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) != 0), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_decode_queue.md
# fpu_decode_queue

Parametrised FP instruction decode stage for the FPU front end. Accepts raw 32-bit F/D-extension instructions over a valid/ready handshake, fully decodes them (including FNMADD, D-format ops, rounding-mode resolution and illegal detection) into a micro-op record, and buffers records in a QDEPTH-entry FIFO. The FPU issue logic drains the FIFO.

## Interface
- FLEN, 32: 32 = F only; 64 = F+D (fmt=01, FLD/FSD, FCVT.S.D/FCVT.D.S legal).
- QDEPTH, 2: FIFO entries, power of 2, ≥2.
- clk  in  1  clock. Single clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop all queued entries; block any push in the same cycle.
- in_valid  in  1  instruction offered.
- in_ready  out  1  `!full && !rst`.
- instr  in  32  raw instruction.
- frm  in  3  fcsr dynamic rounding mode, sampled on push.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head entry.
- op  out  5  micro-op enum (see Operation).
- fmt  out  1  0 = single, 1 = double.
- rd, rs1, rs2, rs3  out  5 each  register fields; 0 when unused by op.
- rm  out  3  resolved rounding mode; 0 when unused.
- imm  out  12  load/store offset; 0 otherwise.
- cls  out  2  00 none/illegal, 01 load, 10 store, 11 arithmetic.
- illegal  out  1  entry is an illegal instruction. Illegal entries are still queued.
- illegal_cnt  out  16  saturating count of illegal pushes.

## Operation
- Op enum values: 0 NONE, 1 LOAD, 2 STORE, 3 MADD, 4 MSUB, 5 NMSUB, 6 NMADD, 7 ADD, 8 SUB, 9 MUL, 10 DIV, 11 SQRT, 12 SGNJ, 13 SGNJN, 14 SGNJX, 15 MIN, 16 MAX, 17 CVT_W, 18 CVT_WU, 19 CVT_F_W, 20 CVT_F_WU, 21 MV_X_F, 22 CLASS, 23 MV_F_X, 24 EQ, 25 LT, 26 LE, 27 CVT_S_D, 28 CVT_D_S.
- Load/store opcodes:
  - 0000111 LOAD and 0100111 STORE.
  - funct3=010 gives fmt 0; funct3=011 gives fmt 1 (FLEN=64 only).
  - Immediate layout: I-type for LOAD, S-type for STORE.
- Fused opcodes (rs3 = instr[31:27], fmt = instr[26:25]):
  - 1000011 MADD, 1000111 MSUB, 1001011 NMSUB, 1001111 NMADD.
- Opcode 1010011: funct5 = instr[31:27], fmt = instr[26:25].
  - 00000 ADD, 00001 SUB, 00010 MUL, 00011 DIV.
  - 01011 SQRT; rs2 must be 0.
  - 00100 SGNJ/SGNJN/SGNJX for funct3 000/001/010.
  - 00101 MIN/MAX for funct3 000/001.
  - 11000 CVT_W/CVT_WU for rs2 0/1.
  - 11010 CVT_F_W/CVT_F_WU for rs2 0/1.
  - 11100 with rs2=0: MV_X_F for funct3 000 (fmt 00 only); CLASS for funct3 001.
  - 11110 MV_F_X; requires funct3=000, rs2=0, fmt 00.
  - 10100 EQ/LT/LE for funct3 010/001/000.
  - 01000 CVT_S_D for fmt 00, rs2=1; CVT_D_S for fmt 01, rs2=0 (FLEN=64 only).
- fmt rules: fmt 10/11 is illegal; fmt 01 is illegal when FLEN=32.
- Rounding mode applies to fused ops, ADD–SQRT and the CVTs:
  - rm field 111 resolves to frm.
  - Resolved value 101 or 110 is illegal.
  - Unused by SGNJ, MIN/MAX, MV, CLASS and compares.
- Illegal record: any other encoding → op=0, cls=00, illegal=1, all register/imm/rm fields 0.
- FIFO:
  - Push on `in_valid && in_ready && !flush`.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo QDEPTH.
  - Outputs are driven from the head entry.
- Flush: next cycle count=0 and out_valid=0. illegal_cnt is not cleared.
- illegal_cnt increments on each illegal push and saturates at 0xFFFF.

## Timing
- Reset (rst high at a clk edge):
  - count, pointers and illegal_cnt = 0; out_valid=0.
  - All record outputs read 0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Latency: a push at edge N gives out_valid=1 from edge N (visible in cycle N+1). No combinational path from instr to out.
- Full: in_ready=0 even when out_ready=1. No path from out_ready to in_ready.
- Empty: out_valid=0 and output fields are don't-care, except after reset where they read 0.
- Stability: while `out_valid && !out_ready`, all outputs hold stable.
- rst mid-stream discards all entries. Priority order: rst > flush > push/pop.

## Test plan
- Reset, then push FADD.S with instr 0x003100D3 and frm=000 → next cycle: out_valid=1, op=7, rd=1, rs1=2, rs2=3, rm=000 (field 000), cls=11.
- FLEN=32, push FMADD.D (fmt 01) → illegal=1, op=0, illegal_cnt=1. Push FADD.S with rm=111 and frm=101 → illegal=1, illegal_cnt=2.
- Push FNMADD.S with rs3=5 and rm=111, frm=010 → op=6, rs3=5, rm=010. Push FSW with imm 0x7FF → op=2, cls=10, imm=0x7FF.
- QDEPTH=2 with out_ready=0: push 3 instructions → in_ready=0 after 2, third held. Raise out_ready → entries emerge in order; the third is accepted the cycle after the first pop.
- Full queue with in_valid=1 and out_ready=1 sustained → one pop and one push per cycle with no bubble after the first pop.
- Flush with in_valid=1 while 2 entries are queued → next cycle out_valid=0, count=0, the offered instruction is not enqueued, illegal_cnt unchanged. Assert rst mid-burst → in_ready=0 while high, out_valid=0 after.
